imem_loader: RTL and testbench

- Writer side of the 16-bit processor's instruction memory. The control unit only reads that memory; this block is what fills it.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 16-bit instruction words. Each word is written sequentially into instruction memory from address 0.
- Holds the processor in reset (`cpu_hold`) until a complete frame passes its checksum.

---
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the 16-bit processor's instruction memory.
// Takes a framed byte stream (COUNT, COUNT little-endian words, CHK) and
// writes each assembled word to consecutive addresses starting at 0. The
// processor stays held in reset until a frame passes its XOR checksum.
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready is 0 only while in reset (it rises on the first edge
// after reset is released); the loader never back-pressures otherwise.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000,
  parameter int TMO_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [8:0]       remaining;
  logic [7:0]       chk;
  logic [TMO_W-1:0] tmo;
  logic             accept;
  logic             in_frame;
  logic             tmo_hit;
  logic             last_word;

  assign accept    = in_valid && in_ready;
  assign in_frame  = (state == LO) || (state == HI) || (state == CHK);
  // The counter would reach TIMEOUT on this edge; an accepted byte wins.
  assign tmo_hit   = in_frame && !accept && (tmo == TMO_W'(TIMEOUT - 1));
  assign last_word = (remaining == 9'd1);

  // Status outputs are pure state decodes, so no input reaches them combinationally.
  assign busy     = in_frame;
  assign load_ok  = (state == DONE);
  assign load_err = (state == ERROR);
  assign cpu_hold = (state != DONE);

  // Ready register: low in reset, high from the first edge afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready <= 1'b0;
    else       in_ready <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: frame sequencing, checksum verdict and timeout abort.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: if (accept) state_nx = LO;
      LO:                if (accept) state_nx = HI;
      HI:                if (accept) state_nx = last_word ? CHK : LO;
      CHK:               if (accept) state_nx = (in_data == chk) ? DONE : ERROR;
      default:           state_nx = IDLE;
    endcase
    if (tmo_hit) state_nx = ERROR;
  end

  // Datapath: word assembly, write strobe, address stepping, checksum, timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= 9'd0;
      chk       <= 8'd0;
      tmo       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 16'd0;
    end else begin
      wr_en <= 1'b0;
      // Address steps at the end of each write cycle; a new COUNT overrides below.
      if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);

      if (!in_frame || accept || tmo_hit) tmo <= '0;
      else                                tmo <= tmo + TMO_W'(1);

      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            chk       <= in_data;
            wr_addr   <= '0;
          end
          LO: begin
            wr_data[7:0] <= in_data;
            chk          <= chk ^ in_data;
          end
          HI: begin
            wr_data[15:8] <= in_data;
            chk           <= chk ^ in_data;
            wr_en         <= 1'b1;
            remaining     <= remaining - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames from the test plan plus random
// frames, with a frame-level reference model feeding an expected-write queue.
module tb_imem_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1000;
  localparam int TMO_W   = 16;

  // Clock / reset
  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              load_ok;
  logic              load_err;
  logic              busy;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .load_ok  (load_ok),
    .load_err (load_err),
    .busy     (busy)
  );

  // Scoreboard state
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [ADDR_W+15:0] exp_q[$];
  logic [ADDR_W+15:0] exp_w;
  logic [7:0]        fr_lo[256];
  logic [7:0]        fr_hi[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe cycle pops one expected {addr,data}.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check("write", {8'd0, wr_addr, wr_data}, {8'd0, exp_w});
      end
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait: got in_ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic ok, input logic err,
                              input logic hold, input logic bsy);
    check({tag, "_load_ok"},  {31'd0, load_ok},  {31'd0, ok});
    check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
    check({tag, "_busy"},     {31'd0, busy},     {31'd0, bsy});
  endtask

  // Reference model at frame level: word k goes to address k with {hi,lo};
  // the frame is good exactly when the sent CHK equals the XOR of all bytes.
  task automatic send_frame(input string tag, input int nw, input logic [7:0] chk_xor,
                            input int gap_max);
    logic [7:0] cnt;
    logic [7:0] sum;
    cnt = 8'(nw);
    sum = cnt;
    send_byte(cnt);
    check_status({tag, "_count"}, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < nw; k++) begin
      idle($urandom_range(0, gap_max));
      send_byte(fr_lo[k]);
      idle($urandom_range(0, gap_max));
      exp_q.push_back({8'(k), fr_hi[k], fr_lo[k]});
      send_byte(fr_hi[k]);
      sum = sum ^ fr_lo[k] ^ fr_hi[k];
    end
    idle($urandom_range(0, gap_max));
    send_byte(sum ^ chk_xor);
    if (chk_xor == 8'd0) check_status({tag, "_end"}, 1'b1, 1'b0, 1'b0, 1'b0);
    else                 check_status({tag, "_end"}, 1'b0, 1'b1, 1'b1, 1'b0);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, {24'd0, 8'(nw)});
  endtask

  // Stimulus
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",   {31'd0, wr_en},   32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_ready",   {31'd0, in_ready}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    idle(1);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Good 2-word frame: 02 35 12 CD AB 43
    fr_lo[0] = 8'h35; fr_hi[0] = 8'h12;
    fr_lo[1] = 8'hCD; fr_hi[1] = 8'hAB;
    send_frame("good2", 2, 8'h00, 0);

    // Reload from DONE: 01 00 90 91
    fr_lo[0] = 8'h00; fr_hi[0] = 8'h90;
    send_frame("reload", 1, 8'h00, 0);

    // Bad checksum: same 2-word frame ending in 44 (43 ^ 07)
    fr_lo[0] = 8'h35; fr_hi[0] = 8'h12;
    fr_lo[1] = 8'hCD; fr_hi[1] = 8'hAB;
    send_frame("badchk", 2, 8'h07, 0);

    // 256-word frame, COUNT = 00
    for (int i = 0; i < 256; i++) begin
      fr_lo[i] = 8'(i);
      fr_hi[i] = 8'hA0;
    end
    send_frame("full256", 256, 8'h00, 0);

    // Stall of 999 cycles is tolerated
    send_byte(8'h01);
    send_byte(8'h35);
    idle(999);
    check_status("stall999", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back({8'h00, 8'h12, 8'h35});
    send_byte(8'h12);
    send_byte(8'h01 ^ 8'h35 ^ 8'h12);
    check_status("stall999_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall of 1000 cycles aborts without writing
    send_byte(8'h01);
    send_byte(8'h35);
    idle(999);
    check_status("stall1000_pre", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check_status("stall1000", 1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    check("stall1000_pending", exp_q.size(), 0);

    // Reset mid-frame: 03 11 22 33 then one cycle of reset
    send_byte(8'h03);
    send_byte(8'h11);
    exp_q.push_back({8'h00, 8'h22, 8'h11});
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("midrst_pending", exp_q.size(), 0);
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    fr_lo[0] = 8'h78; fr_hi[0] = 8'h56;
    send_frame("after_rst", 1, 8'h00, 0);

    // Random frames with random gaps, some with corrupted checksum
    for (int f = 0; f < 20; f++) begin
      int nw;
      logic [7:0] x;
      nw = $urandom_range(1, 12);
      for (int k = 0; k < nw; k++) begin
        fr_lo[k] = 8'($urandom);
        fr_hi[k] = 8'($urandom);
      end
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame("rand", nw, x, 3);
    end

    idle(5);
    check("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
